demapper_pr: RTL and testbench
==============================

// Module: demapper_pr
// PURPOSE
//  Rx inverse of the Tx mapper and pilot-insertion stage: hard-decision QAM demapping plus pilot removal and check.
//  Input: 8 beats per OFDM symbol, each beat 6 data subcarriers (8b I/Q each) and 1 pilot field (4b).
//  Output: demapped bits packed as two 18b words per beat, matching the Tx x0/x1 layout.
//  Flags pilot-polarity errors per symbol. Sits between FFT/equaliser output and deinterleaver.
// PARAMETERS
//  PILOT_SEED  7'h7F  pilot polarity LFSR seed (x^7+x^4+1)
//  CNT_W       8      width of saturating pilot-error counter
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  clear          in   1   sync frame restart: beat:=0, LFSR:=PILOT_SEED, err count:=0
//  run            in   1   input beat valid
//  mod            in   2   0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM; sampled every beat
//  x_in_rx        in   52  [8k+7:8k+4]=I, [8k+3:8k]=Q of subcarrier k (k=0..5, 4b 2's comp); [51:48] pilot field
//  valid_rx       out  1   output beat valid
//  x0             out  18  demapped subcarriers 0..2
//  x1             out  18  demapped subcarriers 3..5
//  sym_end        out  1   high with valid_rx on beat 7 output
//  pilot_err      out  1   with sym_end: >=1 pilot sign mismatch in that symbol
//  pilot_err_cnt  out  8   errored symbols, saturating at 255
// BEHAVIOUR
//  - Reset: all outputs 0; beat counter 0; LFSR = PILOT_SEED; per-symbol error flag 0.
//  - Latency: 1 clk. Beat accepted on run=1 -> valid_rx=1 next cycle; run=0 -> valid_rx=0, x0/x1 hold.
//  - Beat counter 3b: +1 per accepted beat, wraps 7->0; no change when run=0.
//  - Packing, n = 1/2/4/6 bits per subcarrier:
//    subc j at x0[n*j +: n] (j=0..2); subc j+3 at x1[n*j +: n]; unused MSBs = 0.
//  - Slicing (levels odd integers, ties go to larger magnitude):
//    BPSK: b0 = (I>=0).
//    QPSK: b0 = (I>=0), b1 = (Q>=0).
//    16-QAM: b0b1 from I: -3->00, -1->01, +1->11, +3->10 (thresh 0, +/-2); b2b3 same from Q.
//    64-QAM: b0..b2 from I: -7->000, -5->001, -3->011, -1->010, +1->110, +3->111, +5->101, +7->100 (thresh 0, +/-2, +/-4, +/-6); b3..b5 same from Q.
//    b0 = LSB of the n-bit field. Value -8 slices as -7.
//  - Pilot field: sign-magnitude; bit3 = sign, [2:0] ignored. Checked only on beats 0, 2, 4, 6.
//    Expected sign: p on beats 0/2/4, ~p on beat 6; odd-beat pilot field ignored.
//  - p = L[6]^L[3]. L <= {L[5:0], L[6]^L[3]} on each accepted beat 0; beat 0 check uses pre-shift L.
//  - Per-symbol err flag: set on any mismatch, output as pilot_err with sym_end, then cleared.
//  - pilot_err_cnt: +1 per errored symbol at beat-7 output; holds at 255.
//  - clear & run same cycle: clear wins; the beat is processed as beat 0 with seed LFSR and count 0.
//  - clear alone: beat, LFSR, count and flag reset; x0/x1 hold; valid_rx = 0.
//  - mod change mid-symbol: legal; each beat demapped with its own mod.
//  - rst mid-symbol: immediate return to reset state; partial symbol discarded.
// STRUCTURE
//  - Shared package: mod codes, PILOT_SEED, LFSR taps, pilot beat set {0,2,4,6}, slicer threshold constants.
//  - Sub-module demapper: combinational single-subcarrier slicer (x_iq[7:0], mod -> bits[5:0]); 6 instances.
//  - Top: beat counter, pilot LFSR, error flag/counter, output registers.
// TESTING
//  1. BPSK, I = +1,-1,+1,-1,+1,+1 (Q=0) -> next cycle valid_rx=1, x0=18'h5, x1=18'h6.
//  2. 64-QAM, subc0 I=+5, Q=-3 -> x0[5:0]=6'h1D. Repeat with I=+4 -> same result (tie rule).
//  3. Clean symbol after clear: pilots 4'h1 on beats 0/2/4, 4'h9 on beat 6 -> sym_end on beat 7 output, pilot_err=0, cnt=0.
//  4. Same symbol with beat 2 pilot = 4'h9 -> pilot_err=1, cnt=1. 300 such symbols -> cnt=255.
//  5. clear at beat 3, run gaps of 0-3 idle cycles -> next accepted beat treated as beat 0; sym_end exactly 8 beats later.
//  6. rst pulse mid-symbol -> outputs 0 asynchronously; next symbol passes test 3.

Source files
------------

// File: rtl/demapper_pr_pkg.sv
// rtl/demapper_pr_pkg.sv - shared constants and slicing helpers for the QAM demapper
package demapper_pr_pkg;

  // Modulation codes as carried on the mod input
  typedef enum logic [1:0] {
    MOD_BPSK  = 2'd0,
    MOD_QPSK  = 2'd1,
    MOD_QAM16 = 2'd2,
    MOD_QAM64 = 2'd3
  } mod_e;

  // Pilot polarity LFSR (x^7+x^4+1) default seed
  localparam logic [6:0] PILOT_SEED_DEFAULT = 7'h7F;

  // Beats carrying a checked pilot: bit b set means beat b is checked
  localparam logic [7:0] PILOT_BEAT_MASK = 8'b0101_0101;
  // Beat whose pilot carries the inverted polarity
  localparam logic [2:0] PILOT_INV_BEAT  = 3'd6;
  localparam logic [2:0] LAST_BEAT       = 3'd7;

  // Slicer decision thresholds; a sample sitting on a threshold goes to the larger magnitude
  localparam logic signed [3:0] TH_0  = 4'sd0;
  localparam logic signed [3:0] TH_P2 = 4'sd2;
  localparam logic signed [3:0] TH_P4 = 4'sd4;
  localparam logic signed [3:0] TH_P6 = 4'sd6;
  localparam logic signed [3:0] TH_N2 = -4'sd2;
  localparam logic signed [3:0] TH_N4 = -4'sd4;
  localparam logic signed [3:0] TH_N6 = -4'sd6;

  function automatic logic is_pilot_beat(input logic [2:0] beat);
    return PILOT_BEAT_MASK[beat];
  endfunction

  // Polarity bit taken from the LFSR taps
  function automatic logic lfsr_bit(input logic [6:0] l);
    return l[6] ^ l[3];
  endfunction

  function automatic logic [6:0] lfsr_next(input logic [6:0] l);
    return {l[5:0], lfsr_bit(l)};
  endfunction

  // 4-level Gray slicer: -3->00, -1->01, +1->11, +3->10
  function automatic logic [1:0] slice_qam16(input logic signed [3:0] v);
    if (v >= TH_P2)     return 2'b10;
    else if (v >= TH_0) return 2'b11;
    else if (v > TH_N2) return 2'b01;
    else                return 2'b00;
  endfunction

  // 8-level Gray slicer: -7..+7 -> 000,001,011,010,110,111,101,100
  function automatic logic [2:0] slice_qam64(input logic signed [3:0] v);
    if (v >= TH_P6)     return 3'b100;
    else if (v >= TH_P4) return 3'b101;
    else if (v >= TH_P2) return 3'b111;
    else if (v >= TH_0)  return 3'b110;
    else if (v > TH_N2)  return 3'b010;
    else if (v > TH_N4)  return 3'b011;
    else if (v > TH_N6)  return 3'b001;
    else                 return 3'b000;
  endfunction

endpackage

// File: rtl/demapper_pr_demapper.sv
// rtl/demapper_pr_demapper.sv - combinational hard-decision slicer for one subcarrier
module demapper_pr_demapper
  import demapper_pr_pkg::*;
(
  input  logic [7:0] x_iq,
  input  logic [1:0] mod,
  output logic [5:0] bits
);

  logic signed [3:0] i_v;
  logic signed [3:0] q_v;

  assign i_v = x_iq[7:4];
  assign q_v = x_iq[3:0];

  // Slice I into the low field and Q into the field above it; unused MSBs stay 0
  always_comb begin
    bits = '0;
    case (mod)
      MOD_BPSK:  bits[0]   = (i_v >= TH_0);
      MOD_QPSK:  bits[1:0] = {(q_v >= TH_0), (i_v >= TH_0)};
      MOD_QAM16: bits[3:0] = {slice_qam16(q_v), slice_qam16(i_v)};
      MOD_QAM64: bits[5:0] = {slice_qam64(q_v), slice_qam64(i_v)};
      default:   bits      = '0;
    endcase
  end

endmodule

// File: rtl/demapper_pr.sv
// rtl/demapper_pr.sv - Rx hard QAM demapper with pilot removal and polarity check
module demapper_pr
  import demapper_pr_pkg::*;
#(
  parameter logic [6:0] PILOT_SEED = PILOT_SEED_DEFAULT,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [1:0]       mod,
  input  logic [51:0]      x_in_rx,
  output logic             valid_rx,
  output logic [17:0]      x0,
  output logic [17:0]      x1,
  output logic             sym_end,
  output logic             pilot_err,
  output logic [CNT_W-1:0] pilot_err_cnt
);

  logic [5:0]       sc_bits [6];
  logic [17:0]      x0_d;
  logic [17:0]      x1_d;

  logic [2:0]       beat;
  logic [6:0]       lfsr;
  logic             err_flag;
  logic [CNT_W-1:0] err_cnt;

  logic [2:0]       beat_eff;
  logic [6:0]       lfsr_eff;
  logic             flag_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             exp_sign;
  logic             mismatch;
  logic             flag_acc;
  logic             last_beat;

  // Only the pilot sign bit carries information
  logic             unused_pilot_mag;
  assign unused_pilot_mag = ^x_in_rx[50:48];

  genvar k;
  generate
    for (k = 0; k < 6; k++) begin : g_sc
      demapper_pr_demapper u_sc (
        .x_iq (x_in_rx[8*k +: 8]),
        .mod  (mod),
        .bits (sc_bits[k])
      );
    end
  endgenerate

  // Pack three subcarriers per output word at n bits each, matching the Tx layout
  always_comb begin
    x0_d = '0;
    x1_d = '0;
    case (mod)
      MOD_BPSK: begin
        x0_d = {15'b0, sc_bits[2][0], sc_bits[1][0], sc_bits[0][0]};
        x1_d = {15'b0, sc_bits[5][0], sc_bits[4][0], sc_bits[3][0]};
      end
      MOD_QPSK: begin
        x0_d = {12'b0, sc_bits[2][1:0], sc_bits[1][1:0], sc_bits[0][1:0]};
        x1_d = {12'b0, sc_bits[5][1:0], sc_bits[4][1:0], sc_bits[3][1:0]};
      end
      MOD_QAM16: begin
        x0_d = {6'b0, sc_bits[2][3:0], sc_bits[1][3:0], sc_bits[0][3:0]};
        x1_d = {6'b0, sc_bits[5][3:0], sc_bits[4][3:0], sc_bits[3][3:0]};
      end
      default: begin
        x0_d = {sc_bits[2], sc_bits[1], sc_bits[0]};
        x1_d = {sc_bits[5], sc_bits[4], sc_bits[3]};
      end
    endcase
  end

  // Frame-restart view of the state (clear overrides, so a same-cycle beat becomes beat 0) and pilot check
  always_comb begin
    beat_eff  = clear ? 3'd0 : beat;
    lfsr_eff  = clear ? PILOT_SEED : lfsr;
    flag_eff  = clear ? 1'b0 : err_flag;
    cnt_eff   = clear ? '0 : err_cnt;
    cnt_inc   = (&cnt_eff) ? cnt_eff : cnt_eff + 1'b1;
    exp_sign  = lfsr_bit(lfsr_eff) ^ (beat_eff == PILOT_INV_BEAT);
    mismatch  = is_pilot_beat(beat_eff) & (x_in_rx[51] != exp_sign);
    flag_acc  = flag_eff | mismatch;
    last_beat = (beat_eff == LAST_BEAT);
  end

  // Beat counter, pilot LFSR (advances once per symbol on beat 0) and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat     <= 3'd0;
      lfsr     <= PILOT_SEED;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else if (run) begin
      beat <= beat_eff + 3'd1;
      lfsr <= (beat_eff == 3'd0) ? lfsr_next(lfsr_eff) : lfsr_eff;
      if (last_beat) begin
        err_flag <= 1'b0;
        err_cnt  <= flag_acc ? cnt_inc : cnt_eff;
      end else begin
        err_flag <= flag_acc;
        err_cnt  <= cnt_eff;
      end
    end else begin
      beat     <= beat_eff;
      lfsr     <= lfsr_eff;
      err_flag <= flag_eff;
      err_cnt  <= cnt_eff;
    end
  end

  // Output registers: one-cycle latency, data words hold while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_rx  <= 1'b0;
      x0        <= '0;
      x1        <= '0;
      sym_end   <= 1'b0;
      pilot_err <= 1'b0;
    end else begin
      valid_rx  <= run;
      sym_end   <= run & last_beat;
      pilot_err <= run & last_beat & flag_acc;
      if (run) begin
        x0 <= x0_d;
        x1 <= x1_d;
      end
    end
  end

  assign pilot_err_cnt = err_cnt;

endmodule

// File: tb/tb_demapper_pr.sv
// tb/tb_demapper_pr.sv - scoreboard bench for demapper_pr against a behavioural model
module tb_demapper_pr;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        run;
  logic [1:0]  mod;
  logic [51:0] x_in_rx;
  logic        valid_rx;
  logic [17:0] x0;
  logic [17:0] x1;
  logic        sym_end;
  logic        pilot_err;
  logic [7:0]  pilot_err_cnt;

  always #5 clk = ~clk;

  demapper_pr dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .run           (run),
    .mod           (mod),
    .x_in_rx       (x_in_rx),
    .valid_rx      (valid_rx),
    .x0            (x0),
    .x1            (x1),
    .sym_end       (sym_end),
    .pilot_err     (pilot_err),
    .pilot_err_cnt (pilot_err_cnt)
  );

  typedef struct packed {
    logic [17:0] x0;
    logic [17:0] x1;
    logic        se;
    logic        pe;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_push  = 0;
  int          n_pop   = 0;

  int          m_beat;
  logic [6:0]  m_lfsr;
  bit          m_flag;
  int          m_cnt;
  logic [17:0] last_x0;
  logic [17:0] last_x1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Nearest odd constellation level, ties away from zero, clipped to +/-m
  function automatic int level_of(input int v, input int m);
    int a;
    int mag;
    a   = (v < 0) ? -v : v;
    mag = 2 * (a / 2) + 1;
    if (mag > m) mag = m;
    return (v < 0) ? -mag : mag;
  endfunction

  // Gray label of the level's position counted from the most negative level
  function automatic int gray_of(input int v, input int m);
    int i;
    i = (level_of(v, m) + m) / 2;
    return i ^ (i >> 1);
  endfunction

  function automatic bit pilot_p(input logic [6:0] l);
    return l[6] ^ l[3];
  endfunction

  function automatic bit exp_sign_now();
    return pilot_p(m_lfsr) ^ (m_beat == 6);
  endfunction

  task automatic model_reset();
    m_beat = 0;
    m_lfsr = 7'h7F;
    m_flag = 0;
    m_cnt  = 0;
  endtask

  task automatic model_beat(input logic [1:0] md, input logic [51:0] d, input bit clr);
    exp_t e;
    int n, f, iv, qv;
    logic signed [3:0] si, sq;
    if (clr) model_reset();
    n = (md == 2'd0) ? 1 : (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 6;
    e = '0;
    for (int j = 0; j < 6; j++) begin
      si = d[8*j+4 +: 4];
      sq = d[8*j +: 4];
      iv = si;
      qv = sq;
      case (md)
        2'd0:    f = int'(iv >= 0);
        2'd1:    f = int'(iv >= 0) + 2 * int'(qv >= 0);
        2'd2:    f = gray_of(iv, 3) + 4 * gray_of(qv, 3);
        default: f = gray_of(iv, 7) + 8 * gray_of(qv, 7);
      endcase
      if (j < 3) e.x0 = e.x0 | (18'(f) << (n * j));
      else       e.x1 = e.x1 | (18'(f) << (n * (j - 3)));
    end
    if ((m_beat % 2 == 0) && (d[51] != exp_sign_now())) m_flag = 1;
    if (m_beat == 0) m_lfsr = {m_lfsr[5:0], pilot_p(m_lfsr)};
    e.se = (m_beat == 7);
    e.pe = e.se && m_flag;
    if (e.se) begin
      if (m_flag && m_cnt < 255) m_cnt++;
      m_flag = 0;
    end
    e.cnt   = 8'(m_cnt);
    last_x0 = e.x0;
    last_x1 = e.x1;
    sb.push_back(e);
    n_push++;
    m_beat = (m_beat + 1) % 8;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic send_beat(input logic [1:0] md, input logic [51:0] d, input bit clr);
    model_beat(md, d, clr);
    mod     = md;
    x_in_rx = d;
    clear   = clr;
    run     = 1'b1;
    @(posedge clk);
    #1;
    run   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    chk("clear_valid", valid_rx, 0);
    chk("clear_x0_hold", x0, last_x0);
    chk("clear_x1_hold", x1, last_x1);
    chk("clear_cnt", pilot_err_cnt, 0);
  endtask

  function automatic logic [51:0] rand_data(input logic [3:0] pilot);
    logic [51:0] d;
    d[31:0]  = $urandom;
    d[47:32] = 16'($urandom);
    d[51:48] = pilot;
    return d;
  endfunction

  function automatic logic [3:0] good_pilot();
    if (m_beat % 2 == 0) return {exp_sign_now(), 3'($urandom)};
    return 4'($urandom);
  endfunction

  // One symbol with fixed pilots 1 / p2 / 1 / 9 on beats 0/2/4/6
  task automatic send_symbol_fixed(input logic [3:0] p2);
    logic [3:0] p;
    for (int b = 0; b < 8; b++) begin
      case (b)
        0, 4:    p = 4'h1;
        2:       p = p2;
        6:       p = 4'h9;
        default: p = 4'($urandom);
      endcase
      send_beat(2'($urandom), rand_data(p), 1'b0);
    end
  endtask

  // Monitor: every presented output beat is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && valid_rx) begin
      if (sb.size() == 0) begin
        chk("spurious_valid_rx", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("sb_x0", x0, e.x0);
        chk("sb_x1", x1, e.x1);
        chk("sb_sym_end", sym_end, e.se);
        chk("sb_pilot_err", pilot_err, e.pe);
        chk("sb_cnt", pilot_err_cnt, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [51:0] d;
    logic [3:0]  p;
    int          t1i[6];

    rst = 1'b1; clear = 1'b0; run = 1'b0; mod = 2'd0; x_in_rx = '0;
    model_reset();
    last_x0 = '0;
    last_x1 = '0;
    idle(3);
    chk("rst_valid", valid_rx, 0);
    chk("rst_x0", x0, 0);
    chk("rst_x1", x1, 0);
    chk("rst_sym_end", sym_end, 0);
    chk("rst_pilot_err", pilot_err, 0);
    chk("rst_cnt", pilot_err_cnt, 0);
    rst = 1'b0;
    idle(1);

    // BPSK directed pattern
    t1i = '{1, -1, 1, -1, 1, 1};
    d = '0;
    for (int j = 0; j < 6; j++) d[8*j+4 +: 4] = 4'(t1i[j]);
    d[51:48] = 4'h1;
    send_beat(2'd0, d, 1'b0);
    chk("t1_valid", valid_rx, 1);
    chk("t1_x0", x0, 18'h5);
    chk("t1_x1", x1, 18'h6);

    // 64-QAM directed, then the on-threshold tie
    d = rand_data(good_pilot());
    d[7:0] = 8'h5D;
    send_beat(2'd3, d, 1'b0);
    chk("t2_x0_lsb", x0 & 18'h3F, 18'h1D);
    d = rand_data(good_pilot());
    d[7:0] = 8'h4D;
    send_beat(2'd3, d, 1'b0);
    chk("t2_tie_x0_lsb", x0 & 18'h3F, 18'h1D);

    // Clean symbol after clear
    do_clear();
    send_symbol_fixed(4'h1);
    chk("t3_sym_end", sym_end, 1);
    chk("t3_pilot_err", pilot_err, 0);
    chk("t3_cnt", pilot_err_cnt, 0);

    // Errored symbols and counter saturation
    send_symbol_fixed(4'h9);
    chk("t4_pilot_err", pilot_err, 1);
    chk("t4_cnt1", pilot_err_cnt, 1);
    for (int s = 1; s < 300; s++) send_symbol_fixed(4'h9);
    chk("t4_cnt_sat", pilot_err_cnt, 255);

    // Clear at beat 3 with idle gaps
    for (int b = 0; b < 3; b++) begin
      send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
      idle($urandom_range(0, 3));
    end
    do_clear();
    for (int b = 0; b < 8; b++) begin
      idle($urandom_range(0, 3));
      send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
      chk("t5_sym_end", sym_end, (b == 7));
    end
    chk("t5_pilot_err", pilot_err, 0);

    // Clear and run in the same cycle: that beat is beat 0
    send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
    send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
    send_beat(2'($urandom), rand_data(4'h1), 1'b1);
    chk("cr_valid", valid_rx, 1);
    chk("cr_cnt", pilot_err_cnt, 0);
    for (int b = 1; b < 8; b++) send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
    chk("cr_sym_end", sym_end, 1);

    // Asynchronous reset mid-symbol
    for (int b = 0; b < 4; b++) send_beat(2'($urandom), rand_data(good_pilot()), 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", valid_rx, 0);
    chk("t6_x0", x0, 0);
    chk("t6_x1", x1, 0);
    chk("t6_cnt", pilot_err_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    last_x0 = '0;
    last_x1 = '0;
    send_symbol_fixed(4'h1);
    chk("t6_sym_end", sym_end, 1);
    chk("t6_pilot_err", pilot_err, 0);
    chk("t6_cnt_after", pilot_err_cnt, 0);

    // Randomised symbols: mixed mod per beat, occasional wrong pilot, idle gaps
    for (int s = 0; s < 40; s++) begin
      for (int b = 0; b < 8; b++) begin
        p = good_pilot();
        if ($urandom_range(0, 9) == 0) p[3] = ~p[3];
        send_beat(2'($urandom), rand_data(p), 1'b0);
        idle($urandom_range(0, 2));
      end
    end

    idle(2);
    chk("sb_empty", sb.size(), 0);
    chk("sb_push_pop", n_pop, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
